// File: rtl/enc_pkg.sv
// ============================================================================
// Module      : enc_pkg
// Description : Shared defaults and index-width derivation for the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

    localparam int N_DEFAULT = 4;

    // Reset value of every bit of the registered {valid, index} output.
    localparam logic Y_RST = 1'b0;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage : enc_pkg

`default_nettype wire

// File: rtl/priority_encoder_if.sv
// ============================================================================
// Module      : priority_encoder_if
// Description : Request vector and encoded result bundle for priority_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface priority_encoder_if
    import enc_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    localparam int IDX_W = idx_width(N);

    logic [N-1:0]   I;
    logic [IDX_W:0] Y;

    modport master (output I, input  Y);
    modport slave  (input  I, output Y);

endinterface : priority_encoder_if

`default_nettype wire

// File: rtl/prio_enc_comb.sv
// ============================================================================
// Module      : prio_enc_comb
// Description : Combinational MSB-priority encoder of an N-bit request vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc_comb
    import enc_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  wire logic [N-1:0]            I,
    output logic                         valid,
    output logic [idx_width(N)-1:0]      idx
);

    localparam int IDX_W = idx_width(N);

    // Ascending scan: a later (higher) set bit overwrites any lower one.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (I[k]) begin
                valid = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule : prio_enc_comb

`default_nettype wire

// File: rtl/priority_encoder.sv
// ============================================================================
// Module      : priority_encoder
// Description : Priority encoder with registered {valid, index} output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder
    import enc_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    priority_encoder_if.slave  bus
);

    localparam int IDX_W = idx_width(N);

    logic             enc_valid;
    logic [IDX_W-1:0] enc_idx;

    prio_enc_comb #(
        .N (N)
    ) u_prio_enc_comb (
        .I     (bus.I),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.Y <= {(IDX_W+1){Y_RST}};
        end else begin
            bus.Y <= {enc_valid, enc_idx};
        end
    end

endmodule : priority_encoder

`default_nettype wire

// File: tb/tb_priority_encoder.sv
// ============================================================================
// Module      : tb_priority_encoder
// Description : Directed scoreboard bench for priority_encoder (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_encoder;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    priority_encoder_if #(.N(N)) bus ();

    priority_encoder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [IDX_W:0] exp_q[$];
    logic [IDX_W:0] last_y;
    bit             have_last = 1'b0;
    int             errors    = 0;
    int             checks    = 0;

    // Reference: search downward from the MSB, first hit wins.
    function automatic logic [IDX_W:0] model(input logic [N-1:0] in, input logic r);
        int k;
        if (!r) return '0;
        for (k = N - 1; k >= 0; k--) begin
            if (in[k]) return {1'b1, k[IDX_W-1:0]};
        end
        return '0;
    endfunction

    task automatic check(input string tag, input logic [IDX_W:0] obs, input logic [IDX_W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive at negedge, confirm Y has not moved before the edge, then score after it.
    task automatic step(input logic [N-1:0] in, input logic r, input string tag);
        logic [IDX_W:0] e;
        @(negedge clk);
        bus.I = in;
        rst_n = r;
        exp_q.push_back(model(in, r));
        #1;
        if (have_last) check({tag, "_hold"}, bus.Y, last_y);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, bus.Y, e);
        last_y    = e;
        have_last = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.I = '0;
        rst_n = 1'b0;

        step(4'b1111, 1'b0, "rst_edge1");
        step(4'b1111, 1'b0, "rst_edge2");
        step(4'b1111, 1'b1, "rst_release");

        step(4'b1000, 1'b1, "pre_zero");
        step(4'b0000, 1'b1, "zero_after_nz");

        step(4'b0001, 1'b1, "single_b0");
        step(4'b0010, 1'b1, "single_b1");
        step(4'b0100, 1'b1, "single_b2");
        step(4'b1000, 1'b1, "single_b3");

        step(4'b1011, 1'b1, "multi_1011");
        step(4'b0101, 1'b1, "multi_0101");
        step(4'b0011, 1'b1, "multi_0011");
        step(4'b1111, 1'b1, "multi_1111");

        step(4'b0000, 1'b1, "b2b_0000");
        step(4'b1000, 1'b1, "b2b_1000");
        step(4'b1011, 1'b1, "b2b_1011");
        step(4'b0101, 1'b1, "b2b_0101");
        step(4'b0001, 1'b1, "b2b_0001");

        step(4'b0101, 1'b1, "mid_pre");
        step(4'b0101, 1'b0, "mid_rst");
        step(4'b0101, 1'b1, "mid_release");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_priority_encoder

`default_nettype wire
